// File: rtl/shutter_seq_pkg.sv
// Shared encodings and default widths for the shutter frame sequencer.
// Used by the core, the sbus wrapper and the testbench.
package shutter_seq_pkg;

    localparam int CNT_WIDTH_DEF   = 32;
    localparam int FRAME_WIDTH_DEF = 16;
    localparam int T0_LEN_DEF      = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_T0     = 2'd1;
    localparam logic [1:0] ST_OPEN   = 2'd2;
    localparam logic [1:0] ST_CLOSED = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        T0     = ST_T0,
        OPEN   = ST_OPEN,
        CLOSED = ST_CLOSED
    } seq_state_t;

endpackage

// File: rtl/shutter_seq_core_counter.sv
// Loadable down-counter; tc flags the last cycle of a phase (count == 1).
// Holds at zero so it can never wrap.
module seq_down_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 tc
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign tc = (cnt == ONE);

endmodule

// File: rtl/shutter_seq_core.sv
// Timepix3 shutter / T0 / test-pulse frame sequencer.
// Define SHUTTER_SEQ_TPULSE_EN to build the EXT_TPULSE offset generator.
module shutter_seq_core
    import shutter_seq_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int FRAME_WIDTH = FRAME_WIDTH_DEF,
    parameter int T0_LEN      = T0_LEN_DEF
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST,
    input  logic                   START,
    input  logic                   STOP,
    input  logic                   CONF_T0_EN,
    input  logic [CNT_WIDTH-1:0]   CONF_OPEN_CYCLES,
    input  logic [CNT_WIDTH-1:0]   CONF_CLOSED_CYCLES,
    input  logic [FRAME_WIDTH-1:0] CONF_FRAMES,
    input  logic [CNT_WIDTH-1:0]   CONF_TP_DELAY,
    output logic                   SHUTTER,
    output logic                   T0_SYNC,
    output logic                   EXT_TPULSE,
    output logic                   FRAME_START,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [FRAME_WIDTH-1:0] FRAME_CNT
);

    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] T0_VAL = CNT_WIDTH'(T0_LEN);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [CNT_WIDTH-1:0]   cfg_open;
    logic [CNT_WIDTH-1:0]   cfg_closed;
    logic [FRAME_WIDTH-1:0] cfg_frames;
    logic [CNT_WIDTH-1:0]   conf_open_len;
    logic [CNT_WIDTH-1:0]   conf_closed_len;
    logic [FRAME_WIDTH-1:0] fc_inc;

    logic                 accept;
    logic                 ph_load;
    logic [CNT_WIDTH-1:0] ph_val;
    logic                 ph_tc;
    logic                 abort;
    logic                 finish;
    logic                 frame_end;
    logic                 tp_nxt;

    // Zero-length phases run for one cycle; lengths are normalised once at START.
    assign conf_open_len   = (CONF_OPEN_CYCLES == '0) ? ONE : CONF_OPEN_CYCLES;
    assign conf_closed_len = (CONF_CLOSED_CYCLES == '0) ? ONE : CONF_CLOSED_CYCLES;
    assign fc_inc          = FRAME_CNT + 1'b1;
    assign accept          = (state == IDLE) && START && !STOP;

    always_comb begin
        state_nxt = state;
        ph_load   = 1'b0;
        ph_val    = cfg_open;
        abort     = 1'b0;
        finish    = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ph_load = 1'b1;
                    if (CONF_T0_EN) begin
                        state_nxt = T0;
                        ph_val    = T0_VAL;
                    end else begin
                        state_nxt = OPEN;
                        ph_val    = conf_open_len;
                    end
                end
            end
            T0: begin
                if (STOP) begin
                    abort = 1'b1;
                end else if (ph_tc) begin
                    state_nxt = OPEN;
                    ph_load   = 1'b1;
                end
            end
            OPEN: begin
                if (STOP) begin
                    abort = 1'b1;
                end else if (ph_tc) begin
                    frame_end = 1'b1;
                    if (cfg_frames != '0 && fc_inc == cfg_frames) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = CLOSED;
                        ph_load   = 1'b1;
                        ph_val    = cfg_closed;
                    end
                end
            end
            CLOSED: begin
                if (STOP) begin
                    abort = 1'b1;
                end else if (ph_tc) begin
                    state_nxt = OPEN;
                    ph_load   = 1'b1;
                end
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    seq_down_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_phase_cnt (
        .clk     (BUS_CLK),
        .rst     (BUS_RST),
        .load    (ph_load),
        .enable  (state != IDLE),
        .load_val(ph_val),
        .tc      (ph_tc)
    );

`ifdef SHUTTER_SEQ_TPULSE_EN
    logic [CNT_WIDTH-1:0] cfg_tp;
    logic                 tp_load;
    logic [CNT_WIDTH-1:0] tp_val;
    logic                 tp_tc;

    assign tp_load = (state_nxt == OPEN) && (state != OPEN);
    assign tp_val  = (state == IDLE) ? CONF_TP_DELAY : cfg_tp;

    // Counter sits at tc one cycle before the target index.
    assign tp_nxt = tp_load ? (tp_val == '0)
                  : ((state == OPEN) && (state_nxt == OPEN) && tp_tc);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            cfg_tp <= '0;
        end else if (accept) begin
            cfg_tp <= CONF_TP_DELAY;
        end
    end

    seq_down_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_tp_cnt (
        .clk     (BUS_CLK),
        .rst     (BUS_RST),
        .load    (tp_load),
        .enable  (state == OPEN),
        .load_val(tp_val),
        .tc      (tp_tc)
    );
`else
    logic tp_unused;
    assign tp_unused = ^CONF_TP_DELAY;
    assign tp_nxt    = 1'b0;
`endif

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state       <= IDLE;
            SHUTTER     <= 1'b0;
            T0_SYNC     <= 1'b0;
            EXT_TPULSE  <= 1'b0;
            FRAME_START <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            FRAME_CNT   <= '0;
            cfg_open    <= '0;
            cfg_closed  <= '0;
            cfg_frames  <= '0;
        end else begin
            state       <= state_nxt;
            SHUTTER     <= (state_nxt == OPEN);
            T0_SYNC     <= (state_nxt == T0);
            EXT_TPULSE  <= tp_nxt;
            FRAME_START <= (state_nxt == OPEN) && (state != OPEN);
            BUSY        <= (state_nxt != IDLE);
            DONE        <= abort || finish;
            if (accept) begin
                cfg_open   <= conf_open_len;
                cfg_closed <= conf_closed_len;
                cfg_frames <= CONF_FRAMES;
                FRAME_CNT  <= '0;
            end else if (frame_end) begin
                FRAME_CNT <= fc_inc;
            end
        end
    end

endmodule

// File: tb/tb_shutter_seq_core.sv
// Randomised bench for shutter_seq_core against a timeline model:
// outputs are derived arithmetically from cycles elapsed since START.
module tb_shutter_seq_core;
    import shutter_seq_pkg::*;

    localparam int CW = CNT_WIDTH_DEF;
    localparam int FW = FRAME_WIDTH_DEF;
    localparam int TL = T0_LEN_DEF;
`ifdef SHUTTER_SEQ_TPULSE_EN
    localparam bit TP_ON = 1'b1;
`else
    localparam bit TP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          t0_en;
    logic [CW-1:0] open_c;
    logic [CW-1:0] closed_c;
    logic [CW-1:0] tp_d;
    logic [FW-1:0] frames;
    logic          shutter;
    logic          t0_sync;
    logic          ext_tpulse;
    logic          frame_start;
    logic          busy;
    logic          done;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    shutter_seq_core dut (
        .BUS_CLK           (clk),
        .BUS_RST           (rst),
        .START             (start),
        .STOP              (stop),
        .CONF_T0_EN        (t0_en),
        .CONF_OPEN_CYCLES  (open_c),
        .CONF_CLOSED_CYCLES(closed_c),
        .CONF_FRAMES       (frames),
        .CONF_TP_DELAY     (tp_d),
        .SHUTTER           (shutter),
        .T0_SYNC           (t0_sync),
        .EXT_TPULSE        (ext_tpulse),
        .FRAME_START       (frame_start),
        .BUSY              (busy),
        .DONE              (done),
        .FRAME_CNT         (frame_cnt)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model of one run: start cycle s and the latched, normalised config.
    bit run;
    int n;
    int s;
    int m_o;
    int m_c;
    int m_n;
    int m_base;
    int m_tp;
    int m_fc;

    bit e_sh;
    bit e_t0;
    bit e_tp;
    bit e_fs;
    bit e_busy;
    bit e_done;
    int e_fc;

    function automatic int fc_at(input int k);
        int x;
        if (k <= m_base) return 0;
        x = k - 1 - m_base;
        if (x < m_o) return 0;
        return (x - m_o) / (m_o + m_c) + 1;
    endfunction

    // Expected outputs in cycle k after the START cycle.
    task automatic at_k(input int k);
        int x;
        int p;
        int pos;
        p = m_o + m_c;
        if (k <= m_base) begin
            e_t0   = 1'b1;
            e_busy = 1'b1;
            e_fc   = 0;
            m_fc   = 0;
            return;
        end
        x = k - 1 - m_base;
        if (m_n != 0 && x == (m_n - 1) * p + m_o) begin
            e_done = 1'b1;
            e_fc   = m_n;
            m_fc   = m_n;
            run    = 1'b0;
            return;
        end
        pos    = x % p;
        e_sh   = (pos < m_o);
        e_fs   = (pos == 0);
        e_tp   = TP_ON && (pos == m_tp) && (m_tp < m_o);
        e_busy = 1'b1;
        e_fc   = fc_at(k);
        m_fc   = e_fc;
    endtask

    task automatic step(input bit rs, input bit st, input bit sp);
        @(negedge clk);
        rst   = rs;
        start = st;
        stop  = sp;
        @(posedge clk);
        e_sh   = 1'b0;
        e_t0   = 1'b0;
        e_tp   = 1'b0;
        e_fs   = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_fc   = m_fc;
        if (rs) begin
            run  = 1'b0;
            m_fc = 0;
            e_fc = 0;
        end else if (run) begin
            if (sp) begin
                e_done = 1'b1;
                e_fc   = fc_at(n - s);
                m_fc   = e_fc;
                run    = 1'b0;
            end else begin
                at_k(n + 1 - s);
            end
        end else if (st && !sp) begin
            run    = 1'b1;
            s      = n;
            m_o    = (open_c == 0) ? 1 : int'(open_c);
            m_c    = (closed_c == 0) ? 1 : int'(closed_c);
            m_n    = int'(frames);
            m_base = t0_en ? TL : 0;
            m_tp   = int'(tp_d);
            at_k(1);
        end
        n++;
        #1;
        chk("shutter", 32'(shutter), 32'(e_sh));
        chk("t0_sync", 32'(t0_sync), 32'(e_t0));
        chk("ext_tpulse", 32'(ext_tpulse), 32'(e_tp));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_fc));
    endtask

    task automatic set_conf(input bit t0, input int o, input int c,
                            input int f, input int tp);
        t0_en    = t0;
        open_c   = CW'(o);
        closed_c = CW'(c);
        frames   = FW'(f);
        tp_d     = CW'(tp);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        set_conf(0, 0, 0, 0, 0);
        run  = 1'b0;
        n    = 0;
        s    = 0;
        m_fc = 0;

        repeat (3) step(1, 0, 0);

        set_conf(0, 5, 3, 2, 0);
        step(0, 1, 0);
        repeat (16) step(0, 0, 0);

        set_conf(1, 2, 0, 1, 0);
        step(0, 1, 0);
        repeat (8) step(0, 0, 0);

        // Continuous run, stopped in a closed gap after ten frames.
        set_conf(0, 1, 0, 0, 0);
        step(0, 1, 0);
        repeat (19) step(0, 0, 0);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);

        // Stop on the last open cycle of the third frame of four.
        set_conf(0, 3, 2, 4, 0);
        step(0, 1, 0);
        repeat (12) step(0, 0, 0);
        step(0, 0, 1);
        repeat (8) step(0, 0, 0);

        // START and new OPEN length while busy are ignored.
        set_conf(0, 4, 2, 2, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        open_c = CW'(9);
        step(0, 1, 0);
        repeat (14) step(0, 0, 0);

        step(0, 1, 1);
        step(0, 0, 1);

        set_conf(0, 8, 2, 1, 3);
        step(0, 1, 0);
        repeat (10) step(0, 0, 0);
        set_conf(0, 8, 2, 1, 8);
        step(0, 1, 0);
        repeat (10) step(0, 0, 0);

        // Reset mid-run.
        set_conf(1, 3, 1, 0, 1);
        step(0, 1, 0);
        repeat (7) step(0, 0, 0);
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);

        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_conf(1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 6)),
                         int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 7)));
            end
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
